// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the hazard/branch/mult-div/memory sources and the
// pipeline stall controller, and the enables/flushes it drives back.
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             load_use_hazard;
  logic             branch_taken;
  logic             md_start;
  logic             dmem_wait;
  logic             stall_count_clr;
  logic             PCWrite;
  logic             IF_IDWrite;
  logic             ID_EXWrite;
  logic             EX_MEMWrite;
  logic             MEM_WBWrite;
  logic             control_select;
  logic             EX_MEM_bubble;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             md_busy;
  logic [CNT_W-1:0] stall_count;

  // Event sources drive requests and observe the pipeline controls.
  modport master (
    output load_use_hazard, branch_taken, md_start, dmem_wait, stall_count_clr,
    input  PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite, MEM_WBWrite,
           control_select, EX_MEM_bubble, IF_ID_flush, ID_EX_flush,
           md_busy, stall_count
  );

  // The controller consumes requests and produces the pipeline controls.
  modport slave (
    input  load_use_hazard, branch_taken, md_start, dmem_wait, stall_count_clr,
    output PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite, MEM_WBWrite,
           control_select, EX_MEM_bubble, IF_ID_flush, ID_EX_flush,
           md_busy, stall_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline. Priority of
// events: reset, data-memory wait, mult/div freeze, taken branch, load-use.
// A two-state FSM with an 8-bit down-counter times the mult/div freeze, and a
// saturating counter records every cycle in which the PC is held.
module pipeline_stall_controller #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  pipeline_stall_controller_if.slave    bus
);

  typedef enum logic {ST_RUN = 1'b0, ST_MD_BUSY = 1'b1} state_t;

  // The start cycle itself is frozen, so the counter covers the remaining cycles.
  localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_md_cnt;
  logic [7:0]       w_md_cnt_nxt;
  logic [CNT_W-1:0] r_stall_count;
  logic             w_pc_write;

  // FSM state and freeze counter; reset returns to RUN even mid-freeze.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_md_cnt <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Next state: a memory wait holds everything, md_start enters the freeze.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    if (!bus.dmem_wait) begin
      case (r_state)
        ST_RUN: begin
          if (bus.md_start) begin
            w_state_nxt  = ST_MD_BUSY;
            w_md_cnt_nxt = MD_LOAD;
          end
        end
        ST_MD_BUSY: begin
          if (r_md_cnt == 8'd1) begin
            w_state_nxt  = ST_RUN;
            w_md_cnt_nxt = 8'd0;
          end else begin
            w_md_cnt_nxt = r_md_cnt - 8'd1;
          end
        end
        default: begin
          w_state_nxt  = ST_RUN;
          w_md_cnt_nxt = 8'd0;
        end
      endcase
    end
  end

  // Pipeline controls, combinational from state and the prioritised events.
  always_comb begin
    w_pc_write         = 1'b1;
    bus.IF_IDWrite     = 1'b1;
    bus.ID_EXWrite     = 1'b1;
    bus.EX_MEMWrite    = 1'b1;
    bus.MEM_WBWrite    = 1'b1;
    bus.control_select = 1'b0;
    bus.EX_MEM_bubble  = 1'b0;
    bus.IF_ID_flush    = 1'b0;
    bus.ID_EX_flush    = 1'b0;
    bus.md_busy        = 1'b0;
    if (reset) begin
      w_pc_write      = 1'b0;
      bus.IF_IDWrite  = 1'b0;
      bus.ID_EXWrite  = 1'b0;
      bus.EX_MEMWrite = 1'b0;
      bus.MEM_WBWrite = 1'b0;
    end else if (bus.dmem_wait) begin
      w_pc_write      = 1'b0;
      bus.IF_IDWrite  = 1'b0;
      bus.ID_EXWrite  = 1'b0;
      bus.EX_MEMWrite = 1'b0;
      bus.MEM_WBWrite = 1'b0;
      bus.md_busy     = (r_state == ST_MD_BUSY);
    end else if ((r_state == ST_MD_BUSY) || bus.md_start) begin
      // Upstream holds while the mult/div unit occupies EX; bubbles flow on.
      w_pc_write        = 1'b0;
      bus.IF_IDWrite    = 1'b0;
      bus.ID_EXWrite    = 1'b0;
      bus.EX_MEM_bubble = 1'b1;
      bus.md_busy       = 1'b1;
    end else if (bus.branch_taken) begin
      // The flushed instruction no longer needs a load-use stall.
      bus.IF_ID_flush = 1'b1;
      bus.ID_EX_flush = 1'b1;
    end else if (bus.load_use_hazard) begin
      w_pc_write         = 1'b0;
      bus.IF_IDWrite     = 1'b0;
      bus.control_select = 1'b1;
    end
  end

  assign bus.PCWrite = w_pc_write;

  // Saturating stall-cycle counter; clear wins over an increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (bus.stall_count_clr) begin
      r_stall_count <= '0;
    end else if (!w_pc_write && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller with MD_LATENCY=4 and CNT_W=3: a
// directed vector table, a reset-inside-freeze sequence and a randomized run
// against a cycle-level reference model.
module tb_pipeline_stall_controller;

  localparam int MD_LAT = 4;
  localparam int CW     = 3;
  localparam int SAT    = (1 << CW) - 1;

  // {PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite, MEM_WBWrite,
  //  control_select, EX_MEM_bubble, IF_ID_flush, ID_EX_flush, md_busy}
  localparam logic [9:0] O_NORM = 10'b11111_0000_0;
  localparam logic [9:0] O_LU   = 10'b00111_1000_0;
  localparam logic [9:0] O_BR   = 10'b11111_0011_0;
  localparam logic [9:0] O_FRZ  = 10'b00011_0100_1;
  localparam logic [9:0] O_DWR  = 10'b00000_0000_0;
  localparam logic [9:0] O_DWB  = 10'b00000_0000_1;
  localparam logic [9:0] O_RST  = 10'b00000_0000_0;

  typedef struct {
    logic       lu;
    logic       br;
    logic       md;
    logic       dw;
    logic       clr;
    logic [9:0] exp_out;
    int         exp_cnt;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vecs[$];

  pipeline_stall_controller_if #(.CNT_W(CW)) bus ();

  pipeline_stall_controller #(.MD_LATENCY(MD_LAT), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] get_out();
    return {bus.PCWrite, bus.IF_IDWrite, bus.ID_EXWrite, bus.EX_MEMWrite,
            bus.MEM_WBWrite, bus.control_select, bus.EX_MEM_bubble,
            bus.IF_ID_flush, bus.ID_EX_flush, bus.md_busy};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic lu, br, md, dw, clr, input logic [9:0] o, input int c);
    vec_t v;
    v.lu = lu; v.br = br; v.md = md; v.dw = dw; v.clr = clr;
    v.exp_out = o; v.exp_cnt = c;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs just after the edge, then settle to the falling edge.
  task automatic apply(input logic lu, br, md, dw, clr);
    @(posedge clk);
    #1;
    bus.load_use_hazard = lu;
    bus.branch_taken    = br;
    bus.md_start        = md;
    bus.dmem_wait       = dw;
    bus.stall_count_clr = clr;
    @(negedge clk);
  endtask

  // Reference model: freeze expressed as number of frozen cycles still owed.
  int m_rem;
  int m_cnt;

  function automatic logic [9:0] model_out(input logic lu, br, md, dw, input int rem);
    if (dw)                  return (rem > 0) ? O_DWB : O_DWR;
    if (rem > 0 || md)       return O_FRZ;
    if (br)                  return O_BR;
    if (lu)                  return O_LU;
    return O_NORM;
  endfunction

  task automatic model_step(input logic lu, br, md, dw, clr);
    logic [9:0] o;
    o = model_out(lu, br, md, dw, m_rem);
    if (clr)             m_cnt = 0;
    else if (!o[9])      m_cnt = (m_cnt < SAT) ? m_cnt + 1 : SAT;
    if (!dw) begin
      if (m_rem > 0)     m_rem = m_rem - 1;
      else if (md)       m_rem = MD_LAT - 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.load_use_hazard = 1'b0;
    bus.branch_taken    = 1'b0;
    bus.md_start        = 1'b0;
    bus.dmem_wait       = 1'b0;
    bus.stall_count_clr = 1'b0;
    @(negedge clk);
    check("reset_out", get_out(), O_RST);
    check("reset_cnt", bus.stall_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_rem = 0;
    m_cnt = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.load_use_hazard = 1'b0;
    bus.branch_taken    = 1'b0;
    bus.md_start        = 1'b0;
    bus.dmem_wait       = 1'b0;
    bus.stall_count_clr = 1'b0;

    //   lu br md dw clr  outputs  stall_count (before the edge)
    add(0, 0, 0, 0, 0, O_NORM, 0);
    add(0, 0, 0, 0, 0, O_NORM, 0);
    add(0, 0, 0, 0, 0, O_NORM, 0);
    add(1, 0, 0, 0, 0, O_LU,   0);
    add(0, 0, 0, 0, 0, O_NORM, 1);
    add(1, 1, 0, 0, 0, O_BR,   1);
    add(0, 0, 0, 0, 0, O_NORM, 1);
    add(0, 0, 1, 0, 0, O_FRZ,  1);
    add(0, 0, 0, 0, 0, O_FRZ,  2);
    add(1, 1, 0, 0, 0, O_FRZ,  3);
    add(0, 0, 0, 0, 0, O_FRZ,  4);
    add(0, 0, 0, 0, 0, O_NORM, 5);
    add(0, 0, 0, 0, 1, O_NORM, 5);
    add(0, 0, 0, 0, 0, O_NORM, 0);
    add(0, 0, 1, 0, 0, O_FRZ,  0);
    add(0, 0, 0, 1, 0, O_DWB,  1);
    add(0, 0, 0, 1, 0, O_DWB,  2);
    add(0, 0, 0, 0, 0, O_FRZ,  3);
    add(0, 0, 0, 0, 0, O_FRZ,  4);
    add(0, 0, 0, 0, 0, O_FRZ,  5);
    add(0, 0, 0, 0, 0, O_NORM, 6);
    add(1, 0, 0, 0, 1, O_LU,   6);
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 0, O_LU, (i < SAT) ? i : SAT);
    add(0, 0, 0, 0, 0, O_NORM, 7);
    add(0, 1, 1, 0, 0, O_FRZ,  7);
    add(0, 0, 0, 0, 0, O_FRZ,  7);
    add(0, 0, 0, 0, 0, O_FRZ,  7);
    add(0, 0, 0, 0, 0, O_FRZ,  7);
    add(0, 0, 0, 0, 0, O_NORM, 7);
    add(0, 0, 1, 1, 0, O_DWR,  7);
    add(0, 0, 0, 0, 0, O_NORM, 7);
    add(0, 0, 0, 0, 1, O_NORM, 7);
    add(0, 0, 0, 0, 0, O_NORM, 0);

    do_reset();
    foreach (vecs[i]) begin
      apply(vecs[i].lu, vecs[i].br, vecs[i].md, vecs[i].dw, vecs[i].clr);
      check($sformatf("vec%0d_out", i), get_out(), vecs[i].exp_out);
      check($sformatf("vec%0d_cnt", i), bus.stall_count, vecs[i].exp_cnt);
    end

    // Reset asserted inside a mult/div freeze takes effect without a clock edge.
    apply(0, 0, 1, 0, 0);
    check("mdrst_start", get_out(), O_FRZ);
    apply(0, 0, 0, 0, 0);
    check("mdrst_busy", get_out(), O_FRZ);
    check("mdrst_cnt_pre", bus.stall_count, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mdrst_async_out", get_out(), O_RST);
    check("mdrst_async_cnt", bus.stall_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mdrst_release_out", get_out(), O_NORM);
    apply(0, 0, 0, 0, 0);
    check("mdrst_run_out", get_out(), O_NORM);
    check("mdrst_run_cnt", bus.stall_count, 0);

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic lu, br, md, dw, clr;
      lu  = ($urandom_range(3) == 0);
      br  = ($urandom_range(5) == 0);
      md  = ($urandom_range(9) == 0);
      dw  = ($urandom_range(5) == 0);
      clr = ($urandom_range(24) == 0);
      apply(lu, br, md, dw, clr);
      check($sformatf("rnd%0d_out", i), get_out(), model_out(lu, br, md, dw, m_rem));
      check($sformatf("rnd%0d_cnt", i), bus.stall_count, m_cnt);
      model_step(lu, br, md, dw, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges the load-use hazard flag from the hazard detection unit, EX-stage branch resolution, the multi-cycle multiply/divide start, and data-memory wait. It drives every pipeline-register write enable, the ID/EX bubble select, and the flush lines. An internal FSM and down-counter sequence multiply/divide freezes, and a saturating counter records stall cycles for performance measurement.

## Interface
- MD_LATENCY, 32: total freeze cycles per mult/div, including the start cycle; legal range 2..255.
- CNT_W, 16: stall_count width.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- load_use_hazard  in  1  from hazard detection unit: ID/EX load targets a source register of the IF/ID instruction.
- branch_taken  in  1  EX-stage branch/jump resolved taken.
- md_start  in  1  mult/div instruction is in EX this cycle; single-cycle pulse.
- dmem_wait  in  1  data memory not ready; freeze the whole pipeline.
- stall_count_clr  in  1  synchronous clear of stall_count.
- PCWrite  out  1  PC load enable.
- IF_IDWrite  out  1  IF/ID write enable.
- ID_EXWrite  out  1  ID/EX write enable.
- EX_MEMWrite  out  1  EX/MEM write enable.
- MEM_WBWrite  out  1  MEM/WB write enable.
- control_select  out  1  1 = load zeroed control into ID/EX (bubble).
- EX_MEM_bubble  out  1  1 = load zeroed control into EX/MEM.
- IF_ID_flush  out  1  clear IF/ID.
- ID_EX_flush  out  1  clear ID/EX.
- md_busy  out  1  mult/div freeze in progress.
- stall_count  out  CNT_W  count of cycles with PCWrite=0, saturating.

## Operation
- FSM states: RUN and MD_BUSY. Internal md_cnt is 8 bits.
- Outputs are combinational from state and inputs. Priority, highest first: reset, dmem_wait, mult/div freeze, branch_taken, load_use_hazard.
- reset high: all write enables 0, all flushes and bubbles 0, md_busy 0. state=RUN, md_cnt=0, stall_count=0.
- Normal (RUN, no events): all five write enables 1; control_select, EX_MEM_bubble, both flushes 0.
- dmem_wait=1, any state: all five write enables 0, no flush, no bubble.
  - FSM and md_cnt hold.
  - md_busy keeps its current value.
  - md_start and branch_taken are ignored; the requester re-presents them, since EX is held.
- Mult/div freeze applies in RUN with md_start=1, or in MD_BUSY:
  - PCWrite, IF_IDWrite and ID_EXWrite are 0.
  - EX_MEMWrite and MEM_WBWrite are 1, with EX_MEM_bubble=1.
  - md_busy is 1.
- Mult/div transitions:
  - RUN with md_start goes to MD_BUSY and loads md_cnt=MD_LATENCY-1.
  - In MD_BUSY, if md_cnt==1 go to RUN; otherwise decrement md_cnt.
  - branch_taken and load_use_hazard are ignored while frozen.
- branch_taken (RUN, no md_start): IF_ID_flush=1 and ID_EX_flush=1, all write enables 1. A simultaneous load_use_hazard is ignored, because the flushed instruction no longer needs a stall.
- load_use_hazard only (RUN): PCWrite=0, IF_IDWrite=0, control_select=1; other write enables 1.
- md_start together with branch_taken is illegal. md_start wins and the branch is dropped.
- stall_count: on each clock edge with PCWrite=0 (reset low), increment and saturate at 2^CNT_W-1. stall_count_clr has priority and forces 0, even in a stall cycle.

## Timing
- Load-use stall: exactly 1 cycle per hazard. The hazard clears naturally once the bubble occupies ID/EX.
- Branch flush: same cycle as branch_taken; zero extra cycles.
- Mult/div: PCWrite is low for exactly MD_LATENCY consecutive cycles, extended by any dmem_wait cycles. Normal enables return the cycle after the last frozen cycle.
- dmem_wait: no added latency; enables return in the cycle dmem_wait deasserts.
- Reset mid-freeze: the FSM returns to RUN immediately. After reset release, the first cycle has normal enables.
- All state updates happen on the rising clk edge; reset is asynchronous.

## Test plan
- Reset, then idle 3 cycles -> all write enables 1, flushes 0, stall_count=0, md_busy=0.
- load_use_hazard=1 for 1 cycle -> that cycle PCWrite=0, IF_IDWrite=0, control_select=1, ID_EXWrite=1; next edge stall_count=1.
- branch_taken=1 with load_use_hazard=1 in the same cycle -> IF_ID_flush=ID_EX_flush=1, PCWrite=1, control_select=0, stall_count unchanged.
- MD_LATENCY=4, md_start pulse -> PCWrite=0 for exactly 4 cycles, EX_MEM_bubble=1 and md_busy=1 throughout, then normal; stall_count=4.
- MD_LATENCY=4, md_start, then dmem_wait=1 for 2 cycles in MD_BUSY -> PCWrite=0 for 6 cycles, EX_MEMWrite=MEM_WBWrite=0 during the wait; stall_count=6.
- CNT_W=3, hold load_use_hazard for 10 cycles -> stall_count saturates at 7; then stall_count_clr=1 during a stall -> 0. Assert reset inside an MD freeze -> outputs drop immediately, and RUN resumes after release.
